multicycle_ctrl: RTL

- Moore-style controller FSM that sequences a multicycle MIPS datapath through one shared instruction/data memory.
- Memory accesses use a req/ready handshake.
- Supports LW, SW, R-type (add/sub/and/or/slt), BEQ, BNE, ADDI, ORI and J.
- Sits between the instruction register (op/funct) and datapath muxes/enables; flags illegal opcodes and memory timeouts as sticky faults.

---
 rtl/mc_pkg.sv | 71 +++++++
 rtl/mc_funct_dec.sv | 26 ++
 rtl/multicycle_ctrl.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/mc_pkg.sv
// mc_pkg: shared definitions for the multicycle MIPS controller.
//   - state_t       : controller FSM states
//   - OP_* / FN_*   : instruction opcode and R-type funct encodings
//   - ALU_*         : alucontrol codes driven to the datapath ALU
//   - SRCB_* / PCSRC_* : datapath mux select encodings
//   - FAULT_*       : sticky fault codes
package mc_pkg;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXECUTE = 4'd6,
        ALUWB   = 4'd7,
        BRANCH  = 4'd8,
        ADDIEX  = 4'd9,
        ORIEX   = 4'd10,
        IMMWB   = 4'd11,
        JUMP    = 4'd12,
        ERROR   = 4'd13
    } state_t;

    // Opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // R-type funct codes (instr[5:0])
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    // ALU operation codes
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // ALU B-operand select
    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_BRIMM = 2'b11;

    // PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Sticky fault codes
    localparam logic [1:0] FAULT_NONE    = 2'b00;
    localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
    localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

    // States that hold mem_req high and therefore run the wait counter.
    function automatic logic is_mem_state(input state_t s);
        return (s == FETCH) || (s == MEMRD) || (s == MEMWR);
    endfunction

endpackage

// File: rtl/mc_funct_dec.sv
// mc_funct_dec: R-type funct field decoder.
//   funct      in  6  instr[5:0]
//   alucontrol out 3  ALU operation for the funct (ADD when unknown)
//   valid      out 1  funct is one of add/sub/and/or/slt
module mc_funct_dec
    import mc_pkg::*;
(
    input  logic [5:0] funct,
    output logic [2:0] alucontrol,
    output logic       valid
);

    always_comb begin
        alucontrol = ALU_ADD;
        valid      = 1'b1;
        case (funct)
            FN_ADD:  alucontrol = ALU_ADD;
            FN_SUB:  alucontrol = ALU_SUB;
            FN_AND:  alucontrol = ALU_AND;
            FN_OR:   alucontrol = ALU_OR;
            FN_SLT:  alucontrol = ALU_SLT;
            default: valid      = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: Moore controller for a multicycle MIPS datapath sharing one
// instruction/data memory through a req/ready handshake.
//   clk, reset          clock (rising edge), asynchronous active-high reset
//   op, funct           opcode / funct from the instruction register
//   zero                ALU zero flag (branch decision)
//   mem_ready           memory completes the current access this cycle
//   mem_req, memwrite, iord                    memory interface controls
//   irwrite, pcen, regwrite                    datapath register enables
//   regdst, memtoreg, alusrca, alusrcb, extop, pcsrc   datapath mux selects
//   alucontrol          ALU operation
//   instr_done          one-cycle pulse in the last state of each instruction
//   fault               sticky fault code (none / illegal / memory timeout)
module multicycle_ctrl
    import mc_pkg::*;
#(
    parameter int WAIT_W  = 4,
    parameter int TIMEOUT = 15   // must be < 2**WAIT_W
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       memwrite,
    output logic       iord,
    output logic       irwrite,
    output logic       pcen,
    output logic       regwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic       extop,
    output logic [1:0] pcsrc,
    output logic [2:0] alucontrol,
    output logic       instr_done,
    output logic [1:0] fault
);

    state_t              state_reg;
    logic [WAIT_W-1:0]   wait_cnt_reg;
    logic [1:0]          fault_reg;

    logic [2:0]          funct_alu;
    logic                funct_valid;
    logic                wait_expired;

    mc_funct_dec u_funct_dec (
        .funct      (funct),
        .alucontrol (funct_alu),
        .valid      (funct_valid)
    );

    // The cycle in which the counter would reach TIMEOUT is the last stall
    // cycle tolerated: leaving to ERROR here gives exactly TIMEOUT cycles of
    // mem_req without mem_ready.
    assign wait_expired = !mem_ready && (wait_cnt_reg == WAIT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= FETCH;
            wait_cnt_reg <= '0;
            fault_reg    <= FAULT_NONE;
        end else begin
            // Counter is zero in every non-memory state, so it is already
            // clear on entry to FETCH/MEMRD/MEMWR.
            if (is_mem_state(state_reg) && !mem_ready && !wait_expired)
                wait_cnt_reg <= wait_cnt_reg + 1'b1;
            else
                wait_cnt_reg <= '0;

            case (state_reg)
                FETCH: begin
                    if (mem_ready)
                        state_reg <= DECODE;
                    else if (wait_expired) begin
                        state_reg <= ERROR;
                        fault_reg <= FAULT_TIMEOUT;
                    end
                end
                DECODE: begin
                    case (op)
                        OP_LW, OP_SW:   state_reg <= MEMADR;
                        OP_RTYPE: begin
                            if (funct_valid)
                                state_reg <= EXECUTE;
                            else begin
                                state_reg <= ERROR;
                                fault_reg <= FAULT_ILLEGAL;
                            end
                        end
                        OP_BEQ, OP_BNE: state_reg <= BRANCH;
                        OP_ADDI:        state_reg <= ADDIEX;
                        OP_ORI:         state_reg <= ORIEX;
                        OP_J:           state_reg <= JUMP;
                        default: begin
                            state_reg <= ERROR;
                            fault_reg <= FAULT_ILLEGAL;
                        end
                    endcase
                end
                MEMADR:  state_reg <= (op == OP_SW) ? MEMWR : MEMRD;
                MEMRD: begin
                    if (mem_ready)
                        state_reg <= MEMWB;
                    else if (wait_expired) begin
                        state_reg <= ERROR;
                        fault_reg <= FAULT_TIMEOUT;
                    end
                end
                MEMWR: begin
                    if (mem_ready)
                        state_reg <= FETCH;
                    else if (wait_expired) begin
                        state_reg <= ERROR;
                        fault_reg <= FAULT_TIMEOUT;
                    end
                end
                MEMWB, ALUWB, BRANCH, IMMWB, JUMP: state_reg <= FETCH;
                EXECUTE: state_reg <= ALUWB;
                ADDIEX, ORIEX: state_reg <= IMMWB;
                ERROR:   state_reg <= ERROR;
                default: state_reg <= FETCH;
            endcase
        end
    end

    assign fault = fault_reg;

    // Output decode from the state register. Everything is gated by reset so
    // strobes drop immediately on reset assertion, without waiting for the
    // asynchronous state update to propagate.
    always_comb begin
        mem_req    = 1'b0;
        memwrite   = 1'b0;
        iord       = 1'b0;
        irwrite    = 1'b0;
        pcen       = 1'b0;
        regwrite   = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = SRCB_REG;
        extop      = 1'b0;
        pcsrc      = PCSRC_ALU;
        alucontrol = ALU_ADD;
        instr_done = 1'b0;
        if (!reset) begin
            case (state_reg)
                FETCH: begin
                    mem_req = 1'b1;
                    alusrcb = SRCB_FOUR;
                    irwrite = mem_ready;
                    pcen    = mem_ready;
                end
                DECODE:  alusrcb = SRCB_BRIMM;
                MEMADR: begin
                    alusrca = 1'b1;
                    alusrcb = SRCB_IMM;
                end
                MEMRD: begin
                    mem_req = 1'b1;
                    iord    = 1'b1;
                end
                MEMWB: begin
                    regwrite   = 1'b1;
                    memtoreg   = 1'b1;
                    instr_done = 1'b1;
                end
                MEMWR: begin
                    mem_req    = 1'b1;
                    memwrite   = 1'b1;
                    iord       = 1'b1;
                    instr_done = mem_ready;
                end
                EXECUTE: begin
                    alusrca    = 1'b1;
                    alucontrol = funct_alu;
                end
                ALUWB: begin
                    regwrite   = 1'b1;
                    regdst     = 1'b1;
                    instr_done = 1'b1;
                end
                BRANCH: begin
                    alusrca    = 1'b1;
                    alucontrol = ALU_SUB;
                    pcsrc      = PCSRC_ALUOUT;
                    // op[0] is 0 for BEQ, 1 for BNE
                    pcen       = zero ^ op[0];
                    instr_done = 1'b1;
                end
                ADDIEX: begin
                    alusrca = 1'b1;
                    alusrcb = SRCB_IMM;
                end
                ORIEX: begin
                    alusrca    = 1'b1;
                    alusrcb    = SRCB_IMM;
                    extop      = 1'b1;
                    alucontrol = ALU_OR;
                end
                IMMWB: begin
                    regwrite   = 1'b1;
                    instr_done = 1'b1;
                end
                JUMP: begin
                    pcsrc      = PCSRC_JUMP;
                    pcen       = 1'b1;
                    instr_done = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
